// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor: saida = A - B - Bin, LSB first, with start/done handshake.
// Define SUBTRATOR_OVF_EN to compute the signed-overflow flag; otherwise ovf is tied to 0.
module subtrator_serial #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] saida,
    output logic             Bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d, borrow_next, last;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        d           = sa[0] ^ sb[0] ^ borrow;
        borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
        last        = (state == RUN) && (cnt == LAST);
    end

    assign busy = (state != IDLE);

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            saida  <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa     <= A;
                        sb     <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= {d, res[WIDTH-1:1]};
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        saida <= {d, res[WIDTH-1:1]};
                        Bout  <= borrow_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SUBTRATOR_OVF_EN
    // On the last bit, borrow is the borrow into the MSB position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= borrow ^ borrow_next;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: arithmetic reference model, per-cycle compare,
// plus directed vectors with hand-computed results.
module tb_subtrator_serial;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A, B;
    logic         Bin;
    logic         busy, done, Bout, ovf;
    logic [W-1:0] saida;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

`ifdef SUBTRATOR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    subtrator_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .saida(saida), .Bout(Bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline counted from the accepting edge, result from plain arithmetic.
    bit           m_active, m_done, m_bout, m_ovf, p_bout, p_ovf;
    int           m_cnt;
    logic [W-1:0] m_saida, p_saida;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_cnt = 0; m_done = 0;
            m_saida = '0; m_bout = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_done = 1; m_saida = p_saida; m_bout = p_bout; m_ovf = p_ovf;
                end
                if (m_cnt == W + 1) m_active = 0;
            end else if (start) begin
                longint ua, ub, sa_v, sb_v, r;
                ua = longint'(A); ub = longint'(B);
                p_saida = W'(ua - ub - longint'(Bin));
                p_bout  = ua < ub + longint'(Bin);
                sa_v = A[W-1] ? ua - (64'sd1 <<< W) : ua;
                sb_v = B[W-1] ? ub - (64'sd1 <<< W) : ub;
                r = sa_v - sb_v - longint'(Bin);
                p_ovf = OVF_ON && ((r > (64'sd1 <<< (W-1)) - 1) || (r < -(64'sd1 <<< (W-1))));
                m_active = 1; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  32'(busy),  32'(m_active));
            check("done",  32'(done),  32'(m_done));
            check("saida", 32'(saida), 32'(m_saida));
            check("Bout",  32'(Bout),  32'(m_bout));
            check("ovf",   32'(ovf),   32'(m_ovf));
        end
    end

    // Drive one accepted request; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    endtask

    task automatic wait_done(inout int k);
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] es, input logic eb);
        int k = 0;
        start_op(a, b, bin);
        wait_done(k);
        check({tag, "_latency"}, 32'(k), 32'd24);
        check({tag, "_saida"},   32'(saida), 32'(es));
        check({tag, "_Bout"},    32'(Bout), 32'(eb));
        @(negedge clk);
    endtask

    initial begin
        int k, bc, dc, nd;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_saida", 32'(saida), 32'd0);
        check("rst_Bout",  32'(Bout),  32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // 200 - 100: busy for 25 cycles, done at cycle 24
        start_op(24'd200, 24'd100, 1'b0);
        bc = 0; dc = -1;
        while (busy && bc < 200) begin
            if (done) dc = bc;
            bc++;
            @(negedge clk);
        end
        check("op1_busy_cycles", 32'(bc), 32'd25);
        check("op1_done_cycle",  32'(dc), 32'd24);
        check("op1_saida",       32'(saida), 32'd100);
        check("op1_Bout",        32'(Bout), 32'd0);
        check("op1_ovf",         32'(ovf), 32'd0);

        do_op("op2", 24'd200, 24'd100, 1'b1, 24'd99, 1'b0);
        do_op("op3", 24'd100, 24'd200, 1'b0, 24'hFFFF9C, 1'b1);
        check("op3_ovf", 32'(ovf), 32'd0);
        do_op("op4", 24'd0, 24'd0, 1'b1, 24'hFFFFFF, 1'b1);
        do_op("op5", 24'h7FFFFF, 24'hFFFFFF, 1'b0, 24'h800000, 1'b1);
        check("op5_ovf", 32'(ovf), 32'(OVF_ON));
        do_op("op6", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0);

        // Start during busy is ignored; held start gives back-to-back ops every 26 cycles
        start_op(24'd250, 24'd200, 1'b0);
        k = 0;
        repeat (4) @(negedge clk);
        k = 4;
        A = 24'd1; B = 24'd1; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        k++;
        start = 1'b0;
        wait_done(k);
        check("ign_latency", 32'(k), 32'd24);
        check("ign_saida",   32'(saida), 32'd50);
        A = 24'd1; B = 24'd1; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        k++;
        wait_done(k);
        start = 1'b0;
        check("b2b_second_done", 32'(k), 32'd50);
        check("b2b_saida",       32'(saida), 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-operation
        start_op(24'd5, 24'd3, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_done",  32'(done),  32'd0);
        check("arst_saida", 32'(saida), 32'd0);
        check("arst_Bout",  32'(Bout),  32'd0);
        check("arst_ovf",   32'(ovf),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("arst_no_done", 32'(nd), 32'd0);
        do_op("post_rst", 24'd150, 24'd200, 1'b1, 24'hFFFFCD, 1'b1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/subtrator_serial.md
# subtrator_serial

Bit-serial 24-bit subtractor with start/done handshake. Computes saida = A − B − Bin, one bit per clock, LSB first, and reports the final borrow. It is the inverse-operation counterpart of the parallel 24-bit adder in the SD112 arithmetic set. It trades latency for area: one full-subtractor cell, two shift registers and a bit counter.

## Interface
Parameters:
- WIDTH, 24, operand and result width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock; one clock domain, no other clocks.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy = 0.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- Bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse; saida, Bout and ovf are valid from this cycle.
- saida  output  WIDTH  difference, held until the next done.
- Bout  output  1  final borrow-out (1 ⇔ A < B + Bin, unsigned).
- ovf  output  1  signed (two's-complement) overflow; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start = 1: load A into shift register sa, B into sb, and Bin into the borrow flop.
  - Clear the bit counter cnt; go to RUN.
- RUN, each edge:
  - d = sa[0] ^ sb[0] ^ borrow.
  - borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - Shift d into the result shift register at the MSB end; shift sa and sb right by one.
  - Increment cnt.
  - When cnt = WIDTH−1, the last bit is processed: copy the result register to saida and borrow_next to Bout, assert done, and go to DONE.
- DONE: deassert done, return to IDLE. start is ignored in this state.
- start while busy = 1 is ignored; it is neither queued nor allowed to corrupt the operation.
- A, B and Bin may change freely after the accepting edge.
- saida, Bout and ovf change only on the edge that asserts done. They are stable at all other times, including during a following operation.
- Arithmetic is modulo 2^WIDTH. All-ones operands are not special cases. Bin = 1 with A = B gives an all-ones result and Bout = 1.

## Timing
- Reset (rst_n low, any state, asynchronous):
  - State goes to IDLE and cnt = 0.
  - busy = 0, done = 0, saida = 0, Bout = 0, ovf = 0.
  - Any in-flight operation is discarded; no done is produced for it.
- Deassertion: the first edge with rst_n high may accept start.
- Cycle numbering: edge 0 is the edge where start is accepted in IDLE.
- busy is 1 from after edge 0 until after edge WIDTH+1.
- done is 1 from after edge WIDTH to after edge WIDTH+1. That is exactly one cycle, and latency is WIDTH cycles (24 by default).
- Throughput: one operation per WIDTH+2 cycles.
  - The earliest next accept is edge WIDTH+2.
  - start held high continuously gives back-to-back operations at that rate.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Configuration
- SUBTRATOR_OVF_EN defined:
  - Keep the borrow into the MSB position.
  - ovf = (borrow into MSB) ^ Bout, registered with saida on the done edge.
  - ovf flags two's-complement overflow of A − B − Bin.
- SUBTRATOR_OVF_EN undefined:
  - The ovf port still exists and is tied to constant 0.
  - No extra flops are inferred.
  - All other behaviour is identical.

## Test plan
- A=200, B=100, Bin=0, start one cycle → done after 24 cycles; saida=100, Bout=0, ovf=0; busy high for 25 cycles.
- A=200, B=100, Bin=1 → saida=99, Bout=0.
- A=100, B=200, Bin=0 → saida=24'hFFFF9C, Bout=1, ovf=0. Then A=0, B=0, Bin=1 → saida=24'hFFFFFF, Bout=1.
- With SUBTRATOR_OVF_EN, A=24'h7FFFFF, B=24'hFFFFFF, Bin=0 → saida=24'h800000, Bout=1, ovf=1. Without the macro, same stimulus → ovf=0 and the same saida and Bout.
- Accept A=250, B=200. Pulse start again at cycle 5 with A=1, B=1 → the second start is ignored and the first result is 50. Then hold start high → the next accept occurs exactly 26 cycles after the first, and saida stays 50 until the second done.
- Accept an operation, drive rst_n low asynchronously mid-cycle at cycle 10 → busy, done, saida, Bout and ovf go to 0 immediately, and no done follows. After release, A=150, B=200, Bin=1 → saida=24'hFFFFCD, Bout=1.
